// File: rtl/xif_pkg.sv
// Minimal XIF type package: the issue response returned by the coprocessor.
package xif_pkg;

  typedef struct packed {
    logic       accept;     // coprocessor takes ownership of the instruction
    logic       writeback;  // instruction will write back to the host register file
    logic       dualwrite;
    logic [2:0] dualread;
    logic       loadstore;
    logic       ecswrite;
    logic       exc;
  } x_issue_resp_t;

endpackage

// File: rtl/quadrilatero_xif_issue_initiator.sv
// Core-side XIF issue/commit initiator: buffers offload candidates, issues them
// one at a time, and follows every issue handshake with a one-cycle commit.
module quadrilatero_xif_issue_initiator #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [31:0]               rs1_i,
  input  logic [31:0]               rs2_i,
  input  logic                      flush_i,
  output logic                      x_issue_valid_o,
  input  logic                      x_issue_ready_i,
  output logic [31:0]               x_issue_instr_o,
  output logic [ID_WIDTH-1:0]       x_issue_id_o,
  output logic [1:0][31:0]          x_issue_rs_o,
  output logic [1:0]                x_issue_rs_valid_o,
  input  xif_pkg::x_issue_resp_t    x_issue_resp_i,
  output logic                      x_commit_valid_o,
  output logic [ID_WIDTH-1:0]       x_commit_id_o,
  output logic                      x_commit_kill_o,
  output logic                      accepted_o,
  output logic                      rejected_o,
  output logic                      writeback_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_mem [DEPTH];
  logic [31:0]         rs1_mem   [DEPTH];
  logic [31:0]         rs2_mem   [DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ID_WIDTH-1:0] id_q, id_d, commit_id_q, commit_id_d;
  logic                accept_q, accept_d;
  logic                kill_pending_q, kill_pending_d;
  logic                writeback_q, writeback_d;

  logic full, empty, push, issuing, handshake;

  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign instr_ready_o = !full && !flush_i;
  assign push          = instr_valid_i && instr_ready_o;
  assign issuing       = (state_q == ISSUE);
  assign handshake     = issuing && x_issue_ready_i;

  // FIFO storage: written on push, head read combinationally for the issue payload
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wptr_q] <= instr_i;
      rs1_mem[wptr_q]   <= rs1_i;
      rs2_mem[wptr_q]   <= rs2_i;
    end
  end

  // FIFO pointer/occupancy update; a flush keeps only the entry currently on the bus
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (handshake) rptr_d = rptr_q + PTR_W'(1);
    if (flush_i) begin
      if (issuing && !handshake) begin
        // The presented entry must stay stable until its handshake, so it survives.
        wptr_d  = rptr_q + PTR_W'(1);
        count_d = CNT_W'(1);
      end else begin
        wptr_d  = rptr_d;
        count_d = '0;
      end
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (push && !handshake)      count_d = count_q + CNT_W'(1);
      else if (!push && handshake) count_d = count_q - CNT_W'(1);
    end
  end

  // FSM next state; a flushed FIFO never starts a new issue
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty && !flush_i) state_d = ISSUE;
      ISSUE:   if (handshake) state_d = COMMIT;
      COMMIT:  state_d = (!empty && !flush_i) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake capture: ID, accept and writeback of the issued instruction
  always_comb begin
    id_d           = id_q;
    commit_id_d    = commit_id_q;
    accept_d       = accept_q;
    writeback_d    = writeback_q;
    kill_pending_d = kill_pending_q;
    if (handshake) begin
      commit_id_d = id_q;
      accept_d    = x_issue_resp_i.accept;
      id_d        = id_q + ID_WIDTH'(1);
      if (x_issue_resp_i.accept) writeback_d = x_issue_resp_i.writeback;
    end
    // COMMIT always lasts one cycle, so leaving it is the same as being in it.
    if (state_q == COMMIT)             kill_pending_d = 1'b0;
    else if (flush_i && issuing)       kill_pending_d = 1'b1;
  end

  // State and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      id_q           <= '0;
      commit_id_q    <= '0;
      accept_q       <= 1'b0;
      kill_pending_q <= 1'b0;
      writeback_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      id_q           <= id_d;
      commit_id_q    <= commit_id_d;
      accept_q       <= accept_d;
      kill_pending_q <= kill_pending_d;
      writeback_q    <= writeback_d;
    end
  end

  // Output decode; payloads are zeroed whenever their strobe is low
  always_comb begin
    x_issue_valid_o    = issuing;
    x_issue_rs_valid_o = {2{issuing}};
    x_issue_instr_o    = '0;
    x_issue_id_o       = '0;
    x_issue_rs_o       = '0;
    if (issuing) begin
      x_issue_instr_o = instr_mem[rptr_q];
      x_issue_id_o    = id_q;
      x_issue_rs_o[0] = rs1_mem[rptr_q];
      x_issue_rs_o[1] = rs2_mem[rptr_q];
    end
    x_commit_valid_o = (state_q == COMMIT);
    x_commit_id_o    = x_commit_valid_o ? commit_id_q : '0;
    // A flush landing in the commit cycle also kills the instruction committing now.
    x_commit_kill_o  = x_commit_valid_o && (!accept_q || kill_pending_q || flush_i);
    accepted_o       = handshake && x_issue_resp_i.accept;
    rejected_o       = handshake && !x_issue_resp_i.accept;
    writeback_o      = writeback_q;
  end

endmodule

// File: doc/quadrilatero_xif_issue_initiator.md
# quadrilatero_xif_issue_initiator

Core-side initiator for the XIF issue and commit channels of the Quadrilatero matrix coprocessor. It buffers offload candidates from the host pipeline, presents each one on the issue channel, and captures the coprocessor's `x_issue_resp_t`. Every handshaken instruction then gets a one-cycle commit: kill=0 if it was accepted and not flushed, kill=1 otherwise. It sits between the host decode stage and the coprocessor's issue decoder, and is also used as the bench driver for that decoder.

## Interface
Parameters:
- `DEPTH`, 2: input FIFO entries (power of two, ≥2).
- `ID_WIDTH`, 4: width of the instruction ID; IDs wrap modulo 2^ID_WIDTH.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `instr_valid_i` in 1: host offers an instruction.
- `instr_ready_o` out 1: equals !full && !flush_i.
- `instr_i` in 32: instruction word.
- `rs1_i`, `rs2_i` in 32 each: source operands, captured with the instruction.
- `flush_i` in 1: kill all non-committed work.
- `x_issue_valid_o` out 1: issue request valid.
- `x_issue_ready_i` in 1: coprocessor takes the request.
- `x_issue_instr_o` out 32: instruction word.
- `x_issue_id_o` out ID_WIDTH: instruction ID.
- `x_issue_rs_o` out 2x32: operands.
- `x_issue_rs_valid_o` out 2: both bits are 1 whenever `x_issue_valid_o` is 1.
- `x_issue_resp_i` in `xif_pkg::x_issue_resp_t`: response, valid only in the handshake cycle.
- `x_commit_valid_o` out 1: commit strobe.
- `x_commit_id_o` out ID_WIDTH: ID being committed.
- `x_commit_kill_o` out 1: kill flag for that commit.
- `accepted_o` out 1: pulse; issue accepted.
- `rejected_o` out 1: pulse; issue not accepted.
- `writeback_o` out 1: registered `resp.writeback` of the last accepted issue.

## Operation
- FIFO of DEPTH entries; each entry is {instr, rs1, rs2}.
  - Push on instr_valid_i && instr_ready_o.
  - Pop on issue handshake (x_issue_valid_o && x_issue_ready_i).
- FSM has three states: IDLE, ISSUE, COMMIT.
- IDLE: if the FIFO is non-empty, go to ISSUE next cycle.
- ISSUE:
  - x_issue_valid_o=1; payload = FIFO head; ID = id counter.
  - Valid and payload stay stable until the handshake. Valid never drops without a handshake, including under flush_i.
  - On handshake:
    - Latch ID, accept, and writeback.
    - Pulse accepted_o or rejected_o in the same cycle.
    - Increment the ID counter (wraps, e.g. 15→0 for ID_WIDTH=4).
    - Go to COMMIT.
- COMMIT:
  - x_commit_valid_o=1 for exactly one cycle.
  - x_commit_id_o = latched ID.
  - x_commit_kill_o = !accept || kill_pending.
  - Next state is ISSUE if the FIFO is non-empty, else IDLE.
- Flush:
  - flush_i clears all FIFO entries not yet popped. In the flush cycle, a pop (if any) still takes the head.
  - flush_i in ISSUE or COMMIT sets kill_pending, which forces kill=1 on the in-flight instruction's commit.
  - kill_pending clears when the COMMIT state is left.
  - flush_i in IDLE with an empty FIFO has no effect.
- Simultaneous push and flush: flush wins; instr_ready_o is 0, so no push occurs.
- Simultaneous push and pop: both occur; occupancy is unchanged.
- Full FIFO: instr_ready_o=0. A pop in the same cycle does not raise ready (no combinational ready path).
- writeback_o updates only on accepted handshakes and holds otherwise.

## Timing
- Reset values:
  - All outputs 0; FSM=IDLE; FIFO empty; ID counter 0; kill_pending 0.
  - x_issue_* payload outputs are 0.
  - instr_ready_o follows its equation: it reads 1 when flush_i=0.
- Latency, with x_issue_ready_i held high:
  - Push in cycle N, empty FIFO, FSM in IDLE → x_issue_valid_o=1 in cycle N+2 → commit in N+3.
  - Back-to-back throughput is one instruction per 2 cycles (ISSUE→COMMIT→ISSUE).
- x_issue_resp_i is sampled only in the handshake cycle; outside it the value is ignored.
- The commit follows its issue handshake by exactly one cycle. Commits are in issue order, one per handshake.
- Reset asserted mid-operation: outputs drop to their reset values immediately (asynchronous). No commit is emitted for an in-flight instruction; the FIFO contents are lost.

## Test plan
- Single MZERO push, ready=1, resp.accept=1: issue valid at cycle 2 with ID 0; commit at cycle 3 with ID 0, kill=0; accepted_o pulses at cycle 2.
- Unknown opcode 0x0000_0000, resp all zero: rejected_o pulses; commit kill=1; writeback_o keeps its previous value.
- Backpressure: x_issue_ready_i low for 5 cycles. Payload and ID must stay stable with valid held; fill the FIFO to DEPTH and check instr_ready_o=0; release ready and confirm two handshakes with in-order IDs 0 and 1.
- flush_i pulsed during ISSUE with 2 entries queued: the in-flight instruction completes its handshake and commits with kill=1; the FIFO empties; no further issue; the next push uses the next ID.
- ID wrap: 17 accepted instructions with ID_WIDTH=4 produce IDs 0..15, then 0; every commit ID matches its issue ID.
- Reset asserted while in COMMIT: x_commit_valid_o goes low immediately; after release, the FSM is in IDLE, the ID counter restarts at 0, and all outputs are 0.
